tile_spawner: RTL and testbench

- Writer-side counterpart to the board checker. After each accepted move, places one new tile (value 2 or 4) into a pseudo-randomly chosen empty cell of the 4x4 board.
- Sequential scan engine: count empties, pick a target, seek to it, emit a one-cycle write to the board register file.
- Sits between the move/merge unit and the board register. Reports "full" when no empty cell exists; the lose checker consumes that flag.

---
 rtl/tile_spawner_if.sv | 34 +++
 rtl/tile_spawner.sv | 151 +++++++++++++++
 tb/tb_tile_spawner.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/tile_spawner_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tile_spawner_if
// Purpose  : Spawn request/response bundle between the move/merge unit, the
//            tile spawner and the board register write port.
// Revision : 1.0 - initial release
// ============================================================================
interface tile_spawner_if #(
  parameter int TILE_W = 12
) ();
  logic                          start;
  logic [3:0][3:0][TILE_W-1:0]   board_in;
  logic                          busy;
  logic                          done;
  logic                          full;
  logic                          wr_en;
  logic [1:0]                    wr_row;
  logic [1:0]                    wr_col;
  logic [TILE_W-1:0]             wr_val;

  // Requester side: issues start, supplies the board, consumes results
  modport master (
    output start, board_in,
    input  busy, done, full, wr_en, wr_row, wr_col, wr_val
  );

  // Spawner side
  modport slave (
    input  start, board_in,
    output busy, done, full, wr_en, wr_row, wr_col, wr_val
  );
endinterface
`default_nettype wire

// File: rtl/tile_spawner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tile_spawner
// Purpose  : Places one new tile (2 or 4) into a pseudo-randomly chosen empty
//            cell of the 4x4 board: count empties, pick a target ordinal,
//            seek to it, then issue a single-cycle write.
// Revision : 1.0 - initial release
// ============================================================================
module tile_spawner #(
  parameter int          TILE_W      = 12,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          FOUR_THRESH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  tile_spawner_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_PICK  = 3'd2,
    S_SEEK  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11
  localparam logic [15:0]       LFSR_MASK = 16'hB400;
  localparam logic [4:0]        FOUR_T    = 5'(FOUR_THRESH);
  localparam logic [TILE_W-1:0] VAL_TWO   = TILE_W'(2);
  localparam logic [TILE_W-1:0] VAL_FOUR  = TILE_W'(4);

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [3:0]        idx_q, idx_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [3:0]        tgt_q, tgt_d;
  logic [3:0]        seen_q, seen_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        col_q, col_d;
  logic [TILE_W-1:0] val_q, val_d;

  logic              cell_empty;
  logic [3:0]        pick_k;
  logic              pick_four;
  logic              full_now;

  assign cell_empty = (bus.board_in[idx_q[3:2]][idx_q[1:0]] == '0);
  // k = (lfsr[7:0] * count) >> 8; the 12-bit product can never overflow
  assign pick_k     = 4'(({4'b0, lfsr_q[7:0]} * {7'b0, cnt_q}) >> 8);
  assign pick_four  = ({1'b0, lfsr_q[11:8]} < FOUR_T);
  assign full_now   = (state_q == S_PICK) && (cnt_q == 5'd0);

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = full_now || (state_q == S_WRITE);
  assign bus.full   = full_now;
  assign bus.wr_en  = (state_q == S_WRITE);
  assign bus.wr_row = row_q;
  assign bus.wr_col = col_q;
  assign bus.wr_val = val_q;

  // Next-state and datapath updates; LFSR free-runs in every state
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    seen_d  = seen_q;
    row_d   = row_q;
    col_d   = col_q;
    val_d   = val_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_COUNT;
          idx_d   = 4'd0;
          cnt_d   = 5'd0;
        end
      end

      S_COUNT: begin
        if (cell_empty) cnt_d = cnt_q + 5'd1;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = S_PICK;
      end

      S_PICK: begin
        if (cnt_q == 5'd0) begin
          state_d = S_IDLE;
        end else begin
          tgt_d   = pick_k;
          val_d   = pick_four ? VAL_FOUR : VAL_TWO;
          idx_d   = 4'd0;
          seen_d  = 4'd0;
          state_d = S_SEEK;
        end
      end

      S_SEEK: begin
        // Every empty cell is latched so a board that changed under us still
        // ends with the last empty cell seen rather than a stale address.
        if (cell_empty) begin
          row_d = idx_q[3:2];
          col_d = idx_q[1:0];
          if (seen_q == tgt_q) state_d = S_WRITE;
          else                 seen_d  = seen_q + 4'd1;
        end
        if (idx_q == 4'd15) state_d = S_WRITE;
        else                idx_d   = idx_q + 4'd1;
      end

      S_WRITE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      idx_q   <= 4'd0;
      cnt_q   <= 5'd0;
      tgt_q   <= 4'd0;
      seen_q  <= 4'd0;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      seen_q  <= seen_d;
      row_q   <= row_d;
      col_q   <= col_d;
      val_q   <= val_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tile_spawner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tile_spawner
// Purpose  : Self-checking bench for tile_spawner with a cycle-level
//            behavioural reference model of the spawn operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_spawner;

  localparam int          TILE_W      = 12;
  localparam logic [15:0] SEED        = 16'hACE1;
  localparam int          FOUR_THRESH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_spawner_if #(.TILE_W(TILE_W)) bus ();

  tile_spawner #(
    .TILE_W      (TILE_W),
    .LFSR_SEED   (SEED),
    .FOUR_THRESH (FOUR_THRESH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Board model, cell index p = row*4 + col
  logic [TILE_W-1:0] board_m [16];

  for (genvar g = 0; g < 16; g++) begin : g_board
    assign bus.board_in[g/4][g%4] = board_m[g];
  end

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Reference LFSR: advances on every clock out of reset
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= SEED;
    else        lfsr_m <= lstep(lfsr_m);
  end

  int checks = 0;
  int errors = 0;

  // Model of the operation in flight
  bit                in_op     = 1'b0;
  bit                full_case = 1'b0;
  int                cyc       = 0;
  int                end_off   = 0;
  int                exp_p     = 0;
  logic [TILE_W-1:0] exp_val   = '0;
  int                n_acc     = 0;
  int                n_wr      = 0;
  int                n_four    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive start, advance, update the model, compare all outputs
  task automatic tick(input logic s);
    logic [15:0] l;
    int n, k, seen;
    bit ending;
    bus.start = s;
    @(posedge clk);
    #1;
    if (in_op) begin
      if (cyc == end_off) in_op = 1'b0;
      else                cyc++;
    end else if (s) begin
      in_op = 1'b1;
      cyc   = 1;
      n_acc++;
      n = 0;
      for (int i = 0; i < 16; i++) if (board_m[i] == '0) n++;
      if (n == 0) begin
        full_case = 1'b1;
        end_off   = 17;
      end else begin
        // LFSR value seen by the pick step, 16 clocks from now
        l = lfsr_m;
        repeat (16) l = lstep(l);
        k       = (int'(l[7:0]) * n) / 256;
        exp_val = (int'(l[11:8]) < FOUR_THRESH) ? TILE_W'(4) : TILE_W'(2);
        seen  = 0;
        exp_p = -1;
        for (int i = 0; i < 16; i++) begin
          if (board_m[i] == '0) begin
            if (seen == k && exp_p < 0) exp_p = i;
            seen++;
          end
        end
        full_case = 1'b0;
        end_off   = 19 + exp_p;
      end
    end
    ending = in_op && (cyc == end_off);
    chk("busy",  32'(bus.busy),  32'(in_op));
    chk("done",  32'(bus.done),  32'(ending));
    chk("full",  32'(bus.full),  32'(ending && full_case));
    chk("wr_en", 32'(bus.wr_en), 32'(ending && !full_case));
    if (ending && !full_case) begin
      chk("wr_row", 32'(bus.wr_row), 32'(exp_p / 4));
      chk("wr_col", 32'(bus.wr_col), 32'(exp_p % 4));
      chk("wr_val", 32'(bus.wr_val), 32'(exp_val));
      board_m[exp_p] = exp_val;
      n_wr++;
      if (exp_val == TILE_W'(4)) n_four++;
    end
  endtask

  task automatic drain();
    for (int g = 0; g < 64 && in_op; g++) tick(1'b0);
  endtask

  initial begin
    int zeros;
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) board_m[i] = '0;

    // Reset: everything low while held
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_full",  32'(bus.full),  32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_val", 32'(bus.wr_val), 32'd0);
    #4 rst_n = 1'b1;

    // Idle, no start
    repeat (5) tick(1'b0);

    // Full board: done+full at cycle 17, idle at 18
    for (int i = 0; i < 16; i++) board_m[i] = TILE_W'(8);
    tick(1'b1);
    repeat (18) tick(1'b0);

    // Single empty cell at [2][1]
    for (int i = 0; i < 16; i++) board_m[i] = TILE_W'(2);
    board_m[9] = '0;
    tick(1'b1);
    repeat (29) tick(1'b0);

    // 100 back-to-back spawns from an empty board, refilling randomly when full
    for (int i = 0; i < 16; i++) board_m[i] = '0;
    n_wr   = 0;
    n_four = 0;
    for (int s = 0; s < 100; s++) begin
      zeros = 0;
      for (int i = 0; i < 16; i++) if (board_m[i] == '0) zeros++;
      if (zeros == 0) begin
        for (int i = 0; i < 16; i++)
          board_m[i] = ($urandom_range(0, 2) == 0) ? TILE_W'(0)
                                                    : TILE_W'(2 << $urandom_range(0, 9));
      end
      tick(1'b1);
      drain();
    end
    $display("info: random phase wrote %0d tiles, %0d were 4", n_wr, n_four);

    // Start held high on a board with 3 empties
    for (int i = 0; i < 16; i++) board_m[i] = TILE_W'(4);
    zeros = 0;
    while (zeros < 3) begin
      int p;
      p = int'($urandom_range(0, 15));
      if (board_m[p] != '0) begin
        board_m[p] = '0;
        zeros++;
      end
    end
    repeat (40) tick(1'b1);
    drain();

    // Reset in the middle of SEEK (target p=12, SEEK spans cycles 18..30)
    for (int i = 0; i < 16; i++) board_m[i] = TILE_W'(2);
    board_m[12] = '0;
    tick(1'b1);
    repeat (19) tick(1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   32'(bus.busy),   32'd0);
    chk("mid_rst_done",   32'(bus.done),   32'd0);
    chk("mid_rst_wr_en",  32'(bus.wr_en),  32'd0);
    chk("mid_rst_wr_row", 32'(bus.wr_row), 32'd0);
    chk("mid_rst_wr_col", 32'(bus.wr_col), 32'd0);
    chk("mid_rst_wr_val", 32'(bus.wr_val), 32'd0);
    in_op = 1'b0;
    @(posedge clk);
    #1;
    chk("in_rst_wr_en", 32'(bus.wr_en), 32'd0);
    #3 rst_n = 1'b1;
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the run never reaches the summary
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
